token_ring_fifo_dout: RTL

TOKEN_RING_FIFO_DOUT -- requirements
Module: token_ring_fifo_dout

---
 rtl/token_ring_pkg.sv | 46 ++++
 rtl/onehot_to_bin.sv | 34 +++
 rtl/token_ring_fifo_dout.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/token_ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : token_ring_pkg
//  Description : Shared constants and helpers for the token-ring FIFO read
//                side: default payload width / slot count, a one-hot token
//                rotate, and a one-hot integrity check.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package token_ring_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_BUFFER_DEPTH = 8;

  // Helpers operate on a fixed wide vector so a single function serves every
  // depth; callers zero-extend their token and take the low BUFFER_DEPTH bits.
  localparam int MAX_DEPTH = 64;

  typedef logic [MAX_DEPTH-1:0] token_t;

  // Rotate the low 'depth' bits left by one; bit depth-1 wraps to bit 0.
  function automatic token_t token_rotate(input token_t tok, input int depth);
    token_t rot;
    rot = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth) begin
        rot[(i == depth - 1) ? 0 : i + 1] = tok[i];
      end
    end
    return rot;
  endfunction

  // True when exactly one of the low 'depth' bits is set.
  function automatic logic token_is_onehot(input token_t tok, input int depth);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if ((i < depth) && tok[i]) begin
        ones++;
      end
    end
    return (ones == 1);
  endfunction

endpackage : token_ring_pkg
`default_nettype wire

// File: rtl/onehot_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_bin
//  Description : Converts a one-hot token into its binary bit index by OR-ing
//                the indices of all set bits (no priority chain).
//  Ports       : onehot_i [DEPTH-1:0]          one-hot token
//                idx_o    [$clog2(DEPTH)-1:0]  index of the set bit
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_to_bin
  import token_ring_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BUFFER_DEPTH
) (
  input  logic [DEPTH-1:0]         onehot_i,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] w_idx;

  // For a valid one-hot input exactly one term is non-zero.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_idx | (IDX_W'(i) & {IDX_W{onehot_i[i]}});
    end
  end

  assign idx_o = w_idx;

endmodule : onehot_to_bin
`default_nettype wire

// File: rtl/token_ring_fifo_dout.sv
`default_nettype none
// ============================================================================
//  Module      : token_ring_fifo_dout
//  Description : Read side of a token-ring FIFO. A one-hot read token walks
//                the slots written by the producer; the selected slot is
//                loaded into a registered valid/ready output stage. The ring
//                is empty when both tokens match (the writer always leaves
//                one slot free). Malformed tokens raise a sticky error that
//                blocks further fetches.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                buffer_data_i [D*W-1:0]  slot contents, slot k at [k*W +: W]
//                write_token_i [D-1:0]    one-hot next write slot
//                data_o [W-1:0]           registered payload
//                valid_o                  data_o holds an unread entry
//                ready_i                  consumer accepts data_o
//                read_token_o [D-1:0]     one-hot next read slot
//                occupancy_o              ring entries + output register
//                token_error_o            sticky token-integrity fault
//  Revision    : 1.0  initial release
// ============================================================================
module token_ring_fifo_dout
  import token_ring_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_data_i,
  input  logic [BUFFER_DEPTH-1:0]            write_token_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [BUFFER_DEPTH-1:0]            read_token_o,
  output logic [$clog2(BUFFER_DEPTH):0]      occupancy_o,
  output logic                               token_error_o
);

  localparam int IDX_W = $clog2(BUFFER_DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [BUFFER_DEPTH-1:0] C_TOK_RESET = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

  // State
  logic [BUFFER_DEPTH-1:0] r_read_tok_q, w_read_tok_d;
  logic [DATA_WIDTH-1:0]   r_data_q,     w_data_d;
  logic                    r_valid_q,    w_valid_d;
  logic                    r_err_q,      w_err_d;

  // Combinational helpers
  token_t                  w_wr_ext;
  token_t                  w_rd_ext;
  token_t                  w_rd_rot;
  logic                    w_tok_bad;
  logic                    w_ring_empty;
  logic                    w_accept;
  logic                    w_fetch;
  logic [DATA_WIDTH-1:0]   w_slot;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [IDX_W-1:0]        w_rd_idx;
  logic [OCC_W-1:0]        w_ring_cnt;

  always_comb begin
    w_wr_ext                    = '0;
    w_wr_ext[BUFFER_DEPTH-1:0]  = write_token_i;
    w_rd_ext                    = '0;
    w_rd_ext[BUFFER_DEPTH-1:0]  = r_read_tok_q;
  end

  assign w_rd_rot = token_rotate(w_rd_ext, BUFFER_DEPTH);

  // Bits above BUFFER_DEPTH of the rotate result are always zero.
  if (BUFFER_DEPTH < MAX_DEPTH) begin : g_rot_pad
    logic w_rot_pad_unused;
    assign w_rot_pad_unused = |w_rd_rot[MAX_DEPTH-1:BUFFER_DEPTH];
  end else begin : g_rot_full
  end

  assign w_tok_bad    = !token_is_onehot(w_wr_ext, BUFFER_DEPTH)
                     || !token_is_onehot(w_rd_ext, BUFFER_DEPTH);
  assign w_ring_empty = (r_read_tok_q == write_token_i);
  assign w_accept     = r_valid_q && ready_i;

  // A bad token in the current cycle blocks the fetch as well, so a corrupt
  // token can never steer a slot into the output register.
  assign w_fetch = !w_ring_empty && !r_err_q && !w_tok_bad
                && (!r_valid_q || ready_i);

  // AND-OR slot select driven directly by the one-hot read token.
  always_comb begin
    w_slot = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      w_slot = w_slot | (buffer_data_i[k*DATA_WIDTH +: DATA_WIDTH]
                         & {DATA_WIDTH{r_read_tok_q[k]}});
    end
  end

  // Next-state logic
  always_comb begin
    w_read_tok_d = r_read_tok_q;
    w_data_d     = r_data_q;
    w_valid_d    = r_valid_q;
    w_err_d      = r_err_q | w_tok_bad;
    if (w_fetch) begin
      // Covers both an empty output stage and drain-and-refill in one cycle.
      w_data_d     = w_slot;
      w_valid_d    = 1'b1;
      w_read_tok_d = w_rd_rot[BUFFER_DEPTH-1:0];
    end else if (w_accept) begin
      w_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_tok_q <= C_TOK_RESET;
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      r_err_q      <= 1'b0;
    end else begin
      r_read_tok_q <= w_read_tok_d;
      r_data_q     <= w_data_d;
      r_valid_q    <= w_valid_d;
      r_err_q      <= w_err_d;
    end
  end

  // Occupancy: ring distance between tokens plus the output register.
  onehot_to_bin #(.DEPTH(BUFFER_DEPTH)) u_wr_idx (
    .onehot_i (write_token_i),
    .idx_o    (w_wr_idx)
  );

  onehot_to_bin #(.DEPTH(BUFFER_DEPTH)) u_rd_idx (
    .onehot_i (r_read_tok_q),
    .idx_o    (w_rd_idx)
  );

  always_comb begin
    if (w_wr_idx >= w_rd_idx) begin
      w_ring_cnt = OCC_W'(w_wr_idx) - OCC_W'(w_rd_idx);
    end else begin
      w_ring_cnt = OCC_W'(w_wr_idx) + OCC_W'(BUFFER_DEPTH) - OCC_W'(w_rd_idx);
    end
  end

  assign occupancy_o   = w_ring_cnt + OCC_W'(r_valid_q);
  assign data_o        = r_data_q;
  assign valid_o       = r_valid_q;
  assign read_token_o  = r_read_tok_q;
  assign token_error_o = r_err_q;

endmodule : token_ring_fifo_dout
`default_nettype wire
